hazard_scoreboard: RTL and testbench

Parametrised register-hazard scoreboard for the in-order RISC-V pipeline. Sits between decode and issue. Keeps a saturating pending-write counter for each architectural register, stalls issue on read-after-write hazards and on counter saturation, and retires pending writes from up to NWB independent writeback ports. It also provides a whole-scoreboard flush, an optional same-cycle writeback bypass, and a sticky underflow error for verification.

---
 rtl/hazard_scoreboard_pkg.sv | 24 ++
 rtl/hazard_scoreboard_counter.sv | 40 ++++
 rtl/hazard_scoreboard.sv | 133 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared widths and helpers for the register-hazard scoreboard.
// Imported by the scoreboard top and its per-register counters.
package hazard_scoreboard_pkg;

    localparam int CNTW_DEF = 2;
    localparam int NWB_DEF  = 2;
    localparam int MAXW     = 32;

    // Width needed to hold a count of 0..nwb matching writeback ports.
    function automatic int dec_width(input int nwb);
        return (nwb < 1) ? 1 : $clog2(nwb + 1);
    endfunction

    // Number of set bits among the writeback-port match flags.
    function automatic int popcnt(input logic [MAXW-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < MAXW; i++) begin
            n += {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_counter.sv
// Saturating pending-write counter for one architectural register.
// Reports underflow when a writeback would take the count below zero.
module sb_counter
    import hazard_scoreboard_pkg::*;
#(
    parameter int CNTW = CNTW_DEF,
    parameter int DW   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic [DW-1:0]   dec,
    input  logic            clr,
    output logic [CNTW-1:0] cnt,
    output logic            underflow
);

    localparam int NW = ((CNTW > DW) ? CNTW : DW) + 2;

    logic [CNTW-1:0] r_cnt;
    logic [NW-1:0]   w_nxt;

    assign w_nxt     = NW'(r_cnt) + NW'(inc) - NW'(dec);
    assign underflow = w_nxt[NW-1];
    assign cnt       = r_cnt;

    // Count update: reset, flush, then net of allocation and writebacks.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (underflow) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_nxt[CNTW-1:0];
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard between decode and issue.
// Tracks pending writes per register and stalls on RAW or saturation.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREG   = 32,
    parameter int REGSEL = $clog2(NREG),
    parameter int CNTW   = CNTW_DEF,
    parameter int NWB    = NWB_DEF,
    parameter int BYPASS = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rs1v,
    input  logic                    rs2v,
    input  logic                    rdv,
    input  logic [REGSEL-1:0]       rs1,
    input  logic [REGSEL-1:0]       rs2,
    input  logic [REGSEL-1:0]       rd,
    input  logic                    jmp,
    input  logic                    stall_jmp_mem,
    input  logic                    flush,
    input  logic [NWB-1:0]          we,
    input  logic [NWB*REGSEL-1:0]   rdwbs,
    output logic                    stall,
    output logic                    busy,
    output logic [REGSEL+CNTW-1:0]  outstanding,
    output logic                    err_underflow
);

    localparam int DW = dec_width(NWB);
    localparam int OW = REGSEL + CNTW;
    localparam logic [CNTW-1:0] CMAX = '1;

    logic [CNTW-1:0] w_cnt [NREG];
    logic [CNTW-1:0] w_eff [NREG];
    logic [NREG-1:0] w_uf;
    logic            w_stall;
    logic            w_alloc;
    logic            w_busy;
    logic [OW-1:0]   w_sum;
    logic [OW-1:0]   r_out;
    logic            r_err;

    genvar g;
    for (g = 0; g < NREG; g++) begin : g_reg
        if (g == 0) begin : g_zero
            assign w_cnt[g] = '0;
            assign w_eff[g] = '0;
            assign w_uf[g]  = 1'b0;
        end else begin : g_trk
            logic [MAXW-1:0]    w_m;
            logic [DW-1:0]      w_dec;
            logic [CNTW+DW-1:0] w_ce;
            logic [CNTW+DW-1:0] w_de;

            // Flag every writeback port targeting this register.
            always_comb begin
                w_m = '0;
                for (int k = 0; k < NWB; k++) begin
                    w_m[k] = we[k] &
                        (rdwbs[k*REGSEL +: REGSEL] == REGSEL'(g));
                end
            end

            assign w_dec = DW'(popcnt(w_m));
            assign w_ce  = (CNTW+DW)'(w_cnt[g]);
            assign w_de  = (CNTW+DW)'(w_dec);

            if (BYPASS != 0) begin : g_byp
                assign w_eff[g] = (w_ce > w_de) ?
                    CNTW'(w_ce - w_de) : '0;
            end else begin : g_reg_only
                assign w_eff[g] = w_cnt[g];
            end

            sb_counter #(
                .CNTW (CNTW),
                .DW   (DW)
            ) u_cnt (
                .clk       (clk),
                .rst       (rst),
                .inc       (w_alloc && (rd == REGSEL'(g))),
                .dec       (w_dec),
                .clr       (flush),
                .cnt       (w_cnt[g]),
                .underflow (w_uf[g])
            );
        end
    end

    // Hazard check; a taken jump or flush never stalls issue.
    always_comb begin
        w_stall = 1'b0;
        if (!jmp && !flush) begin
            w_stall = (rs1v && (w_eff[rs1] != '0)) ||
                      (rs2v && (w_eff[rs2] != '0)) ||
                      (rdv && (rd != '0) && (w_cnt[rd] == CMAX));
        end
    end

    assign w_alloc = rdv && (rd != '0) && !jmp && !stall_jmp_mem &&
                     !w_stall && !flush;

    // Occupancy summary over all tracked registers.
    always_comb begin
        w_busy = 1'b0;
        w_sum  = '0;
        for (int r = 0; r < NREG; r++) begin
            w_busy = w_busy | (|w_cnt[r]);
            w_sum  = w_sum + OW'(w_cnt[r]);
        end
    end

    // Registered outstanding total and sticky underflow flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out <= '0;
            r_err <= 1'b0;
        end else begin
            r_out <= w_sum;
            if (!flush && (|w_uf)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign stall         = w_stall;
    assign busy          = w_busy;
    assign outstanding   = r_out;
    assign err_underflow = r_err;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard, registered and bypass variants.
// Expected values are hand-derived from the scoreboard behaviour.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       rs1v, rs2v, rdv;
    logic [4:0] rs1, rs2, rd;
    logic       jmp, stall_jmp_mem, flush;
    logic [1:0] we;
    logic [9:0] rdwbs;

    logic       stall0, busy0, err0;
    logic [6:0] out0;
    logic       stall1, busy1, err1;
    logic [6:0] out1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.BYPASS(0)) u0 (
        .clk(clk), .rst(rst),
        .rs1v(rs1v), .rs2v(rs2v), .rdv(rdv),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .jmp(jmp), .stall_jmp_mem(stall_jmp_mem), .flush(flush),
        .we(we), .rdwbs(rdwbs),
        .stall(stall0), .busy(busy0),
        .outstanding(out0), .err_underflow(err0)
    );

    hazard_scoreboard #(.BYPASS(1)) u1 (
        .clk(clk), .rst(rst),
        .rs1v(rs1v), .rs2v(rs2v), .rdv(rdv),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .jmp(jmp), .stall_jmp_mem(stall_jmp_mem), .flush(flush),
        .we(we), .rdwbs(rdwbs),
        .stall(stall1), .busy(busy1),
        .outstanding(out1), .err_underflow(err1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rs1v = 0; rs2v = 0; rdv = 0;
        rs1 = 0; rs2 = 0; rd = 0;
        jmp = 0; stall_jmp_mem = 0; flush = 0;
        we = 0; rdwbs = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 0;
        tick(); tick();
        rst = 1;
        #1;
        chk("rst_stall", {31'd0, stall0}, 0);
        chk("rst_busy", {31'd0, busy0}, 0);
        chk("rst_out", {25'd0, out0}, 0);
        chk("rst_err", {31'd0, err0}, 0);

        // allocate x5, then read it
        rdv = 1; rd = 5; #1;
        chk("alloc5_stall", {31'd0, stall0}, 0);
        tick();
        idle(); rs1v = 1; rs1 = 5; #1;
        chk("raw5_stall", {31'd0, stall0}, 1);
        chk("raw5_busy", {31'd0, busy0}, 1);
        tick();
        chk("raw5_out", {25'd0, out0}, 1);
        chk("raw5_stall2", {31'd0, stall0}, 1);

        // writeback x5 with the reader waiting
        we = 2'b01; rdwbs = {5'd0, 5'd5}; #1;
        chk("wb5_stall_reg", {31'd0, stall0}, 1);
        chk("wb5_stall_byp", {31'd0, stall1}, 0);
        tick();
        we = 0; #1;
        chk("after_wb5_stall", {31'd0, stall0}, 0);
        tick();
        chk("after_wb5_out", {25'd0, out0}, 0);
        chk("after_wb5_busy", {31'd0, busy0}, 0);

        // saturate x7
        idle(); rdv = 1; rd = 7;
        tick(); tick(); #1;
        chk("sat7_third_stall", {31'd0, stall0}, 0);
        tick();
        chk("sat7_fourth_stall", {31'd0, stall0}, 1);
        tick();
        chk("sat7_out", {25'd0, out0}, 3);
        chk("sat7_hold_stall", {31'd0, stall0}, 1);
        we = 2'b01; rdwbs = {5'd0, 5'd7}; #1;
        chk("sat7_wb_stall", {31'd0, stall0}, 1);
        tick();
        we = 0; #1;
        chk("sat7_proceed", {31'd0, stall0}, 0);
        tick();
        rdv = 0;
        tick();
        chk("sat7_out_back", {25'd0, out0}, 3);
        rdv = 1; rd = 7; #1;
        chk("sat7_again", {31'd0, stall0}, 1);

        // drain x7
        idle(); we = 2'b11; rdwbs = {5'd7, 5'd7};
        tick();
        we = 2'b01; rdwbs = {5'd0, 5'd7};
        tick();
        idle();
        tick();
        chk("drain7_busy", {31'd0, busy0}, 0);
        chk("drain7_out", {25'd0, out0}, 0);
        chk("drain7_err", {31'd0, err0}, 0);

        // dual writeback on x9, then underflow
        rdv = 1; rd = 9;
        tick(); tick();
        idle(); we = 2'b11; rdwbs = {5'd9, 5'd9};
        tick();
        idle(); #1;
        chk("dual9_busy", {31'd0, busy0}, 0);
        chk("dual9_err", {31'd0, err0}, 0);
        tick();
        we = 2'b11; rdwbs = {5'd9, 5'd9};
        tick();
        idle(); #1;
        chk("uf9_err", {31'd0, err0}, 1);
        tick(); tick();
        chk("uf9_sticky", {31'd0, err0}, 1);

        // jump and external stall suppress allocation
        rdv = 1; rd = 3;
        tick();
        idle(); rs1v = 1; rs1 = 3; #1;
        chk("x3_hazard", {31'd0, stall0}, 1);
        jmp = 1; rdv = 1; rd = 4; #1;
        chk("jmp_stall", {31'd0, stall0}, 0);
        tick();
        idle(); rs1v = 1; rs1 = 4; #1;
        chk("jmp_no_alloc", {31'd0, stall0}, 0);
        idle(); stall_jmp_mem = 1; rdv = 1; rd = 4;
        tick();
        idle(); rs2v = 1; rs2 = 4; #1;
        chk("ext_no_alloc", {31'd0, stall0}, 0);
        tick();
        chk("jmp_out", {25'd0, out0}, 1);

        // flush with a writeback on one pending register
        idle(); rdv = 1; rd = 6;
        tick();
        rd = 8;
        tick();
        rd = 10;
        tick();
        idle();
        tick();
        chk("pre_flush_out", {25'd0, out0}, 4);
        flush = 1; we = 2'b01; rdwbs = {5'd0, 5'd6};
        rs1v = 1; rs1 = 6; #1;
        chk("flush_stall_reg", {31'd0, stall0}, 0);
        chk("flush_stall_byp", {31'd0, stall1}, 0);
        tick();
        idle(); rs1v = 1; rs1 = 6; #1;
        chk("post_flush_stall", {31'd0, stall0}, 0);
        chk("post_flush_busy", {31'd0, busy0}, 0);
        chk("post_flush_err", {31'd0, err0}, 1);
        tick();
        chk("post_flush_out", {25'd0, out0}, 0);

        // reset clears the sticky flag
        idle(); rst = 0;
        tick();
        rst = 1; #1;
        chk("rst2_err", {31'd0, err0}, 0);
        chk("rst2_busy", {31'd0, busy0}, 0);

        // register-zero traffic
        for (int i = 0; i < 10; i++) begin
            rdv = 1; rd = 0; rs1v = 1; rs1 = 0; rs2v = 1; rs2 = 0;
            we = 2'b11; rdwbs = 10'd0; #1;
            chk("x0_stall_reg", {31'd0, stall0}, 0);
            chk("x0_stall_byp", {31'd0, stall1}, 0);
            chk("x0_busy", {31'd0, busy0}, 0);
            chk("x0_err", {31'd0, err0}, 0);
            tick();
        end
        idle();
        tick();
        chk("x0_out", {25'd0, out0}, 0);
        chk("x0_err_byp", {31'd0, err1}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
